// File: rtl/controller_ports_pkg.sv
// Shared definitions for the controller port block: CPU register addresses,
// the CPU read direction encoding and the pad scan state enumeration.
package controller_ports_pkg;

  localparam logic [15:0] ADDRESS_JOY1 = 16'h4016;
  localparam logic [15:0] ADDRESS_JOY2 = 16'h4017;
  localparam logic        RW_READ      = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LOW,
    CLK_HIGH,
    COMMIT
  } scan_state_t;

endpackage

// File: rtl/controller_scan.sv
// Periodic serial pad scanner. Every SCAN_INTERVAL cycles it latches all pads,
// clocks REPORT_BITS bits out of each (active-low on the wire), and commits the
// complete set of reports to the shadow register in a single cycle, so readers
// never see a half-updated report.
module controller_scan
  import controller_ports_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int REPORT_BITS   = 8,
  parameter int SCAN_DIV      = 6,
  parameter int SCAN_INTERVAL = 83333
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic [NUM_PORTS-1:0]             i_pad_data,
  output logic                             o_pad_latch,
  output logic                             o_pad_clk,
  output logic                             o_scan_busy,
  output logic [NUM_PORTS*REPORT_BITS-1:0] o_shadow
);

  localparam int IW = $clog2(SCAN_INTERVAL);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(REPORT_BITS);

  localparam logic [IW-1:0] INTERVAL_LAST = IW'(SCAN_INTERVAL - 1);
  localparam logic [PW-1:0] PHASE_LAST    = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PHASE_RISE    = PW'(SCAN_DIV - 2);
  localparam logic [BW-1:0] BIT_LAST      = BW'(REPORT_BITS - 1);

  scan_state_t                      r_state;
  logic [IW-1:0]                    r_interval;
  logic [PW-1:0]                    r_phase;
  logic [BW-1:0]                    r_bit;
  logic                             r_pad_latch;
  logic                             r_pad_clk;
  logic [REPORT_BITS-1:0]           r_capture [NUM_PORTS];
  logic [NUM_PORTS*REPORT_BITS-1:0] r_shadow;

  // Free-running interval counter; wraps after SCAN_INTERVAL-1 whatever the FSM does.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_interval <= '0;
    end else if (r_interval == INTERVAL_LAST) begin
      r_interval <= '0;
    end else begin
      r_interval <= r_interval + 1'b1;
    end
  end

  // Scan FSM with registered pad outputs, bit capture and atomic commit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_bit       <= '0;
      r_pad_latch <= 1'b0;
      r_pad_clk   <= 1'b1;
      r_shadow    <= '0;
      // NOTE: the capture array is explicitly reset; a scan cut short by reset
      // must never leak stale bits into a later commit.
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_capture[p] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (r_interval == INTERVAL_LAST) begin
            r_state     <= LATCH;
            r_phase     <= '0;
            r_bit       <= '0;
            r_pad_latch <= 1'b1;
          end
        end
        LATCH: begin
          if (r_phase == PHASE_LAST) begin
            r_state     <= CLK_LOW;
            r_phase     <= '0;
            r_pad_latch <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        CLK_LOW: begin
          // Pad clock is still high here; the pad is presenting bit r_bit.
          if (r_phase == PHASE_LAST) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
              r_capture[p][r_bit] <= ~i_pad_data[p];
            end
            r_state   <= CLK_HIGH;
            r_phase   <= '0;
            r_pad_clk <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        CLK_HIGH: begin
          // Raise the pad clock for the final cycle: one rising edge per bit.
          if (r_phase == PHASE_RISE) begin
            r_pad_clk <= 1'b1;
          end
          if (r_phase == PHASE_LAST) begin
            r_phase <= '0;
            if (r_bit == BIT_LAST) begin
              r_state <= COMMIT;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_state <= CLK_LOW;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        COMMIT: begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            r_shadow[p*REPORT_BITS +: REPORT_BITS] <= r_capture[p];
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_pad_latch = r_pad_latch;
  assign o_pad_clk   = r_pad_clk;
  assign o_scan_busy = (r_state != IDLE);
  assign o_shadow    = r_shadow;

endmodule

// File: rtl/controller_ports.sv
// CPU-facing controller ports at $4016/$4017. Holds the strobe bit, one read
// shift register per port and the address decode; pad scanning lives in
// controller_scan. Port p reads at $4016+(p mod 2) on data bit (p div 2).
// Build option CONTROLLER_OPEN_BUS_EN: drive the $40 open-bus pattern on
// o_data[7:5] for hit reads; otherwise the upper bits read 0.
module controller_ports
  import controller_ports_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int REPORT_BITS   = 8,
  parameter int SCAN_DIV      = 6,
  parameter int SCAN_INTERVAL = 83333
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_clk_en,
  input  logic [15:0]                      i_address,
  input  logic                             i_rw,
  input  logic [7:0]                       i_data,
  output logic [7:0]                       o_data,
  output logic                             o_data_hit,
  output logic                             o_pad_latch,
  output logic                             o_pad_clk,
  input  logic [NUM_PORTS-1:0]             i_pad_data,
  output logic [NUM_PORTS*REPORT_BITS-1:0] o_buttons,
  output logic                             o_scan_busy
);

  localparam int RB = REPORT_BITS;

  logic                    w_hit;
  logic                    w_sel;
  logic                    w_write_strobe;
  logic                    w_read_shift;
  logic [7:0]              w_data;
  logic [NUM_PORTS*RB-1:0] w_shadow;
  logic [6:0]              w_unused_data;

  logic                    r_strobe;
  logic [RB-1:0]           r_shift [NUM_PORTS];

  controller_scan #(
    .NUM_PORTS    (NUM_PORTS),
    .REPORT_BITS  (REPORT_BITS),
    .SCAN_DIV     (SCAN_DIV),
    .SCAN_INTERVAL(SCAN_INTERVAL)
  ) u_scan (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_pad_data (i_pad_data),
    .o_pad_latch(o_pad_latch),
    .o_pad_clk  (o_pad_clk),
    .o_scan_busy(o_scan_busy),
    .o_shadow   (w_shadow)
  );

  // Address decode: bit 0 of the address selects the even or odd port group.
  assign w_hit          = (i_address == ADDRESS_JOY1) || (i_address == ADDRESS_JOY2);
  assign w_sel          = i_address[0];
  assign w_write_strobe = i_clk_en && (i_rw != RW_READ) && (i_address == ADDRESS_JOY1);
  assign w_read_shift   = i_clk_en && (i_rw == RW_READ) && w_hit && !r_strobe;
  assign w_unused_data  = i_data[7:1];

  // Strobe bit written from data bit 0 at $4016; $4017 writes do nothing.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_strobe <= 1'b0;
    end else if (w_write_strobe) begin
      r_strobe <= i_data[0];
    end
  end

  // Per-port read shift registers: reload while strobed, else shift on reads.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_shift[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_strobe) begin
          r_shift[p] <= w_shadow[p*RB +: RB];
        end else if (w_read_shift && (w_sel == 1'(p % 2))) begin
          r_shift[p] <= {1'b1, r_shift[p][RB-1:1]};
        end
      end
    end
  end

  // Combinational read mux: addressed ports' bit 0 onto their data lines.
  // NOTE: w_data gets a default before any branch so no latch is inferred.
  always_comb begin
    w_data = '0;
    if (w_hit) begin
`ifdef CONTROLLER_OPEN_BUS_EN
      w_data[7:5] = 3'b010;
`endif
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_sel == 1'(p % 2)) begin
          w_data[p/2] = r_shift[p][0];
        end
      end
    end
  end

  assign o_data     = w_data;
  assign o_data_hit = w_hit;
  assign o_buttons  = w_shadow;

endmodule

// File: tb/tb_controller_ports.sv
// Self-checking bench for controller_ports: a behavioural pad model drives the
// serial lines, a read model predicts each CPU read, and a monitor compares
// every hit read against the predicted queue.
module tb_controller_ports;

  localparam int NP       = 4;
  localparam int RB       = 8;
  localparam int DIV      = 2;
  localparam int INTERVAL = 300;
  localparam int TIMEOUT  = 2 * INTERVAL + 200;

  logic            clk      = 1'b0;
  logic            reset_n  = 1'b0;
  logic            clk_en   = 1'b0;
  logic [15:0]     address  = 16'h0000;
  logic            rw       = 1'b1;
  logic [7:0]      wdata    = 8'h00;
  logic [7:0]      rdata;
  logic            hit;
  logic            pad_latch;
  logic            pad_clk;
  logic [NP-1:0]   pad_data;
  logic [NP*RB-1:0] buttons;
  logic            scan_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  controller_ports #(
    .NUM_PORTS    (NP),
    .REPORT_BITS  (RB),
    .SCAN_DIV     (DIV),
    .SCAN_INTERVAL(INTERVAL)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_clk_en   (clk_en),
    .i_address  (address),
    .i_rw       (rw),
    .i_data     (wdata),
    .o_data     (rdata),
    .o_data_hit (hit),
    .o_pad_latch(pad_latch),
    .o_pad_clk  (pad_clk),
    .i_pad_data (pad_data),
    .o_buttons  (buttons),
    .o_scan_busy(scan_busy)
  );

  // Pad model: latch reloads the report, each rising pad clock advances one bit.
  logic [RB-1:0] pad_val [NP];
  int            pad_idx = 0;

  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pad_idx <= 0;
    else           pad_idx <= pad_idx + 1;
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      pad_data[p] = (pad_idx < RB) ? ~pad_val[p][pad_idx] : 1'b1;
    end
  end

  // Read model: committed reports, report snapshot taken at strobe release,
  // and the number of reads consumed per port since then.
  logic [RB-1:0] m_shadow [NP];
  logic [RB-1:0] m_snap   [NP];
  int            m_cnt    [NP];
  logic          m_strobe;
  logic [7:0]    exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_strobe = 1'b0;
    for (int p = 0; p < NP; p++) begin
      m_shadow[p] = '0;
      m_snap[p]   = '0;
      m_cnt[p]    = 0;
    end
  endtask

  task automatic model_read(input logic [15:0] addr, output logic [7:0] exp);
    logic b;
    exp = 8'h00;
`ifdef CONTROLLER_OPEN_BUS_EN
    exp[7:5] = 3'b010;
`endif
    for (int p = 0; p < NP; p++) begin
      if ((p % 2) == int'(addr - 16'h4016)) begin
        if (m_strobe) begin
          b = m_shadow[p][0];
        end else begin
          b = (m_cnt[p] < RB) ? m_snap[p][m_cnt[p]] : 1'b1;
          m_cnt[p]++;
        end
        exp[p/2] = b;
      end
    end
  endtask

  task automatic idle_bus();
    clk_en  = 1'b0;
    rw      = 1'b1;
    address = 16'h0000;
    wdata   = 8'h00;
  endtask

  // All bus operations start 1 time unit after a rising edge and last one cycle.
  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] d);
    logic rising;
    rising = 1'b0;
    clk_en  = 1'b1;
    rw      = 1'b0;
    address = addr;
    wdata   = d;
    if (addr == 16'h4016) begin
      rising = d[0] && !m_strobe;
      if (m_strobe && !d[0]) begin
        for (int p = 0; p < NP; p++) begin
          m_snap[p] = m_shadow[p];
          m_cnt[p]  = 0;
        end
      end
      m_strobe = d[0];
    end
    @(posedge clk); #1;
    idle_bus();
    // The shift registers reload on the edge after the strobe rises.
    if (rising) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic cpu_read(input logic [15:0] addr, input logic en);
    logic [7:0] exp;
    clk_en  = en;
    rw      = 1'b1;
    address = addr;
    if (en) begin
      model_read(addr, exp);
      exp_q.push_back(exp);
    end
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic nonhit_access(input logic [15:0] addr, input logic is_read);
    clk_en  = 1'b1;
    rw      = is_read;
    address = addr;
    wdata   = 8'hff;
    #2;
    check("nonhit_data", rdata, 8'h00);
    check("nonhit_hit", hit, 1'b0);
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic wait_scan(output int edges, output logic ok);
    int   cyc;
    logic prev;
    edges = 0;
    ok    = 1'b1;
    cyc   = 0;
    while (!scan_busy && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!scan_busy) begin
      ok = 1'b0;
      return;
    end
    prev = pad_clk;
    cyc  = 0;
    while (scan_busy && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
      if (pad_clk && !prev) edges++;
      prev = pad_clk;
    end
    if (scan_busy) ok = 1'b0;
  endtask

  task automatic scan_and_commit(input string tag);
    int            edges;
    logic          ok;
    logic [NP*RB-1:0] exp_btn;
    wait_scan(edges, ok);
    check({tag, "_scan_done"}, ok, 1'b1);
    check({tag, "_pad_edges"}, edges, RB);
    for (int p = 0; p < NP; p++) begin
      m_shadow[p]          = pad_val[p];
      exp_btn[p*RB +: RB]  = pad_val[p];
    end
    check({tag, "_buttons"}, buttons, exp_btn);
  endtask

  // Monitor: every enabled hit read is compared with the oldest prediction.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (clk_en && rw && hit) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL read_unexpected: got %0h expected no read", rdata);
        end else begin
          exp = exp_q.pop_front();
          check("read_data", rdata, exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_rst;
    int         falls;
    int         cyc;
    int         nops;
    logic       prev;

    for (int p = 0; p < NP; p++) pad_val[p] = 8'h00;
    model_reset();
    idle_bus();

    // Reset state.
    #12;
    check("rst_pad_clk", pad_clk, 1'b1);
    check("rst_pad_latch", pad_latch, 1'b0);
    check("rst_busy", scan_busy, 1'b0);
    check("rst_buttons", buttons, '0);
    address = 16'h4016;
    #1;
    exp_rst = 8'h00;
`ifdef CONTROLLER_OPEN_BUS_EN
    exp_rst[7:5] = 3'b010;
`endif
    check("rst_hit", hit, 1'b1);
    check("rst_read_4016", rdata, exp_rst);
    check("rst_open_bus", rdata[7:5], exp_rst[7:5]);
    address = 16'h0000;
    #1;
    check("rst_nonhit_data", rdata, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed: A+Start on pad 0, only the last bit on pad 3.
    pad_val[0] = 8'h09;
    pad_val[1] = 8'($urandom_range(0, 255));
    pad_val[2] = 8'($urandom_range(0, 255));
    pad_val[3] = 8'h80;
    scan_and_commit("directed");
    check("directed_pad0", buttons[7:0], 8'h09);
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) cpu_read(16'h4016, 1'b1);
    for (int i = 0; i < 8; i++)  cpu_read(16'h4017, 1'b1);
    cpu_write(16'h4016, 8'h01);
    for (int i = 0; i < 3; i++)  cpu_read(16'h4016, 1'b1);
    cpu_write(16'h4016, 8'h00);
    for (int i = 0; i < 3; i++)  cpu_read(16'h4016, 1'b1);
    nonhit_access(16'h4015, 1'b1);
    nonhit_access(16'h4018, 1'b0);

    // Randomized scans and CPU traffic.
    for (int it = 0; it < 20; it++) begin
      for (int p = 0; p < NP; p++) pad_val[p] = 8'($urandom_range(0, 255));
      scan_and_commit("random");
      if ($urandom_range(0, 1) == 1) begin
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
      end
      nops = $urandom_range(4, 16);
      for (int k = 0; k < nops; k++) begin
        case ($urandom_range(0, 9))
          0: cpu_write(16'h4016, 8'($urandom_range(0, 255)));
          1: cpu_write(16'h4017, 8'($urandom_range(0, 255)));
          2: nonhit_access(16'h4000 + 16'($urandom_range(0, 21)), 1'($urandom_range(0, 1)));
          3: cpu_read(16'h4016 + 16'($urandom_range(0, 1)), 1'b0);
          4: begin @(posedge clk); #1; end
          default: cpu_read(16'h4016 + 16'($urandom_range(0, 1)), 1'b1);
        endcase
      end
    end

    // Reset during CLK_HIGH of bit 4 abandons the scan.
    if (m_strobe) cpu_write(16'h4016, 8'h00);
    for (int p = 0; p < NP; p++) pad_val[p] = 8'($urandom_range(1, 255));
    scan_and_commit("pre_reset");
    cyc = 0;
    while (!scan_busy && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    falls = 0;
    prev  = pad_clk;
    cyc   = 0;
    while (falls < 5 && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
      if (!pad_clk && prev) falls++;
      prev = pad_clk;
    end
    check("midscan_reached", falls, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("midscan_rst_pad_clk", pad_clk, 1'b1);
    check("midscan_rst_pad_latch", pad_latch, 1'b0);
    check("midscan_rst_buttons", buttons, '0);
    check("midscan_rst_busy", scan_busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    while (!scan_busy && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("restart_interval", cyc, INTERVAL);
    scan_and_commit("post_reset");
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    for (int i = 0; i < 9; i++) cpu_read(16'h4017, 1'b1);

    @(posedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_ports.md
CONTROLLER_PORTS -- requirements
Module: controller_ports

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of controller ports (legal 1..4).
REQ-002 Parameter REPORT_BITS, default 8, serial bits per controller report (legal 8..24).
REQ-003 Parameter SCAN_DIV, default 6, i_clk cycles per pad latch/clock half-phase (legal >=2).
REQ-004 Parameter SCAN_INTERVAL, default 83333, i_clk cycles between scan starts (legal > scan length).
REQ-005 i_clk  in  1  system clock; the block uses this single clock.
REQ-006 i_reset_n  in  1  asynchronous active-low reset.
REQ-007 i_clk_en  in  1  CPU clock enable; CPU accesses are qualified by it.
REQ-008 i_address  in  16  CPU address.
REQ-009 i_rw  in  1  CPU direction, 1 = read.
REQ-010 i_data  in  8  CPU write data.
REQ-011 o_data  out  8  CPU read data.
REQ-012 o_data_hit  out  1  high when i_address is $4016 or $4017.
REQ-013 o_pad_latch  out  1  latch to all pads, high = latch.
REQ-014 o_pad_clk  out  1  shift clock to all pads, idle high; pads advance on rising edge.
REQ-015 i_pad_data  in  NUM_PORTS  serial pad data, active-low (0 = pressed).
REQ-016 o_buttons  out  NUM_PORTS*REPORT_BITS  committed shadow reports, active-high, port p at bits [p*REPORT_BITS +: REPORT_BITS].
REQ-017 o_scan_busy  out  1  high while the scan FSM is not IDLE.

Function
REQ-018 Scan FSM states: IDLE, LATCH, CLK_LOW, CLK_HIGH, COMMIT.
REQ-019 IDLE -> LATCH when the interval counter reaches SCAN_INTERVAL-1; the counter then wraps to 0 and runs free.
REQ-020 LATCH: o_pad_latch=1 for SCAN_DIV cycles, then -> CLK_LOW.
REQ-021 CLK_LOW: o_pad_clk=1 (no edge yet), latch=0, SCAN_DIV cycles; on its last cycle capture ~i_pad_data into bit n of each port's capture register (n = 0 first).
REQ-022 CLK_HIGH: o_pad_clk=0 for SCAN_DIV-1 cycles then 1 on the last cycle (one rising edge per bit); -> CLK_LOW while n < REPORT_BITS-1, else -> COMMIT.
REQ-023 COMMIT: one cycle; all capture registers copied to shadow (o_buttons) atomically; -> IDLE.
REQ-024 Write with i_clk_en, i_rw=0, i_address=$4016 sets strobe <= i_data[0]; $4017 writes are ignored.
REQ-025 While strobe=1, every cycle each port's CPU shift register loads that port's shadow value.
REQ-026 Port p is read at address $4016+(p mod 2), on data bit (p div 2); unread bits in [1:0] are 0.
REQ-027 o_data is combinational: the addressed ports' shift-register bit 0 on the mapped bits.
REQ-028 Read with i_clk_en, i_rw=1, strobe=0 shifts the addressed ports' registers right by one at that edge, filling with 1 (exhausted reports read 1).
REQ-029 Strobe load and COMMIT in the same cycle: the load takes the pre-commit shadow.
REQ-030 Non-hit addresses: o_data=0, o_data_hit=0, no state change.

Reset
REQ-031 On i_reset_n low, immediately: FSM IDLE, interval counter 0, bit index 0, strobe 0, capture/shadow/shift registers 0, o_pad_latch 0, o_pad_clk 1, o_scan_busy 0.
REQ-032 Reset mid-scan abandons the scan; the shadow keeps its reset value 0, with no partial commit.

Configuration
REQ-033 Macro CONTROLLER_OPEN_BUS_EN defined: on a hit, o_data[7:5]=3'b010 (the $40 open-bus pattern); undefined: o_data[7:2]=0.

Structure
REQ-034 Shared package controller_ports_pkg holds ADDRESS_JOY1 ($4016), ADDRESS_JOY2 ($4017), RW_READ, and the scan-state enum.
REQ-035 Sub-module controller_scan holds the scan FSM, interval counter, capture and shadow registers; the top holds strobe, shift registers and the CPU decode.

Verification
REQ-036 Pad 0 drives A+Start (pattern 0b00001001 pressed), SCAN_DIV=2 -> after COMMIT, o_buttons[7:0]=8'h09 and 8 rising edges of o_pad_clk are seen.
REQ-037 Write $01 then $00 to $4016, then read $4016 10 times -> D0 = 1,0,0,1,0,0,0,0,1,1.
REQ-038 Strobe held 1, read $4016 three times -> D0 stays at shadow bit 0; the shift register does not advance.
REQ-039 NUM_PORTS=4, port 3 = 8'h80 -> reads of $4017 return bit 0 of D1 = 0,0,0,0,0,0,0,1.
REQ-040 Assert reset during CLK_HIGH of bit 4 -> o_pad_clk=1, o_pad_latch=0, o_buttons=0 immediately, and the next scan starts after SCAN_INTERVAL cycles.
REQ-041 Read $4016 with and without CONTROLLER_OPEN_BUS_EN -> o_data[7:5] is 3'b010 with the macro and 3'b000 without.
